// File: rtl/alu_issue_dec_pkg.sv
// ============================================================================
// Module : alu_issue_dec_pkg
// Brief  : MIPS opcode/funct fields, ALU control codes and decode record type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_issue_dec_pkg;

  localparam int MD_MUL_CYCLES = 1;
  localparam int MD_DIV_CYCLES = 32;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_SPECIAL3 = 6'b010000;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LH       = 6'b100001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_LHU      = 6'b100101;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;
  localparam logic [5:0] FN_ERET  = 6'h18;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;
  localparam logic [4:0] RS_MFC0   = 5'b00000;
  localparam logic [4:0] RS_MTC0   = 5'b00100;
  localparam logic [4:0] RS_ERET   = 5'b10000;

  localparam logic [4:0] AND_CONTROL   = 5'd1;
  localparam logic [4:0] OR_CONTROL    = 5'd2;
  localparam logic [4:0] XOR_CONTROL   = 5'd3;
  localparam logic [4:0] NOR_CONTROL   = 5'd4;
  localparam logic [4:0] LUI_CONTROL   = 5'd5;
  localparam logic [4:0] SLL_CONTROL   = 5'd6;
  localparam logic [4:0] SRL_CONTROL   = 5'd7;
  localparam logic [4:0] SRA_CONTROL   = 5'd8;
  localparam logic [4:0] SLLV_CONTROL  = 5'd9;
  localparam logic [4:0] SRLV_CONTROL  = 5'd10;
  localparam logic [4:0] SRAV_CONTROL  = 5'd11;
  localparam logic [4:0] ADD_CONTROL   = 5'd12;
  localparam logic [4:0] ADDU_CONTROL  = 5'd13;
  localparam logic [4:0] SUB_CONTROL   = 5'd14;
  localparam logic [4:0] SUBU_CONTROL  = 5'd15;
  localparam logic [4:0] SLT_CONTROL   = 5'd16;
  localparam logic [4:0] SLTU_CONTROL  = 5'd17;
  localparam logic [4:0] MULT_CONTROL  = 5'd18;
  localparam logic [4:0] MULTU_CONTROL = 5'd19;
  localparam logic [4:0] DIV_CONTROL   = 5'd20;
  localparam logic [4:0] DIVU_CONTROL  = 5'd21;
  localparam logic [4:0] MFHI_CONTROL  = 5'd22;
  localparam logic [4:0] MFLO_CONTROL  = 5'd23;
  localparam logic [4:0] MTHI_CONTROL  = 5'd24;
  localparam logic [4:0] MTLO_CONTROL  = 5'd25;
  localparam logic [4:0] MTC0_CONTROL  = 5'd26;
  localparam logic [4:0] MFC0_CONTROL  = 5'd27;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       ri;
    logic       md;
    logic       mul;
    logic       div;
  } dec_t;

  function automatic dec_t dec_ok(input logic [4:0] c);
    dec_t d;
    d      = '0;
    d.ctrl = c;
    return d;
  endfunction

  function automatic dec_t dec_md(input logic [4:0] c, input logic mul, input logic div);
    dec_t d;
    d      = '0;
    d.ctrl = c;
    d.md   = 1'b1;
    d.mul  = mul;
    d.div  = div;
    return d;
  endfunction

  function automatic dec_t dec_ri();
    dec_t d;
    d    = '0;
    d.ri = 1'b1;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// Module : alu_op_decode
// Brief  : Combinational instruction-field to ALU control / reserved decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
  import alu_issue_dec_pkg::*;
#(
  parameter int ENABLE_MD = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic [4:0] control,
  output logic       ri,
  output logic       md_class,
  output logic       is_mul,
  output logic       is_div
);

  dec_t raw;
  dec_t dec;

  always_comb begin
    raw = dec_ok(5'd0);
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:   raw = dec_ok(AND_CONTROL);
          FN_NOR:   raw = dec_ok(NOR_CONTROL);
          FN_OR:    raw = dec_ok(OR_CONTROL);
          FN_XOR:   raw = dec_ok(XOR_CONTROL);
          FN_SLLV:  raw = dec_ok(SLLV_CONTROL);
          FN_SLL:   raw = dec_ok(SLL_CONTROL);
          FN_SRAV:  raw = dec_ok(SRAV_CONTROL);
          FN_SRA:   raw = dec_ok(SRA_CONTROL);
          FN_SRLV:  raw = dec_ok(SRLV_CONTROL);
          FN_SRL:   raw = dec_ok(SRL_CONTROL);
          FN_ADD:   raw = dec_ok(ADD_CONTROL);
          FN_ADDU:  raw = dec_ok(ADDU_CONTROL);
          FN_SUB:   raw = dec_ok(SUB_CONTROL);
          FN_SUBU:  raw = dec_ok(SUBU_CONTROL);
          FN_SLT:   raw = dec_ok(SLT_CONTROL);
          FN_SLTU:  raw = dec_ok(SLTU_CONTROL);
          FN_JALR:  raw = dec_ok(ADDU_CONTROL);
          FN_MFHI:  raw = dec_md(MFHI_CONTROL, 1'b0, 1'b0);
          FN_MTHI:  raw = dec_md(MTHI_CONTROL, 1'b0, 1'b0);
          FN_MFLO:  raw = dec_md(MFLO_CONTROL, 1'b0, 1'b0);
          FN_MTLO:  raw = dec_md(MTLO_CONTROL, 1'b0, 1'b0);
          FN_MULT:  raw = dec_md(MULT_CONTROL, 1'b1, 1'b0);
          FN_MULTU: raw = dec_md(MULTU_CONTROL, 1'b1, 1'b0);
          FN_DIV:   raw = dec_md(DIV_CONTROL, 1'b0, 1'b1);
          FN_DIVU:  raw = dec_md(DIVU_CONTROL, 1'b0, 1'b1);
          default:  raw = dec_ri();
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     raw = dec_ok(5'd0);
          RT_BLTZAL, RT_BGEZAL: raw = dec_ok(ADDU_CONTROL);
          default:              raw = dec_ri();
        endcase
      end
      OP_SPECIAL3: begin
        if (rs == RS_MTC0)                          raw = dec_ok(MTC0_CONTROL);
        else if (rs == RS_MFC0)                     raw = dec_ok(MFC0_CONTROL);
        else if (rs == RS_ERET && funct == FN_ERET) raw = dec_ok(5'd0);
        else                                        raw = dec_ri();
      end
      OP_ANDI:  raw = dec_ok(AND_CONTROL);
      OP_ORI:   raw = dec_ok(OR_CONTROL);
      OP_XORI:  raw = dec_ok(XOR_CONTROL);
      OP_LUI:   raw = dec_ok(LUI_CONTROL);
      OP_ADDI:  raw = dec_ok(ADD_CONTROL);
      OP_ADDIU: raw = dec_ok(ADDU_CONTROL);
      OP_SLTI:  raw = dec_ok(SLT_CONTROL);
      OP_SLTIU: raw = dec_ok(SLTU_CONTROL);
      OP_JAL, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
                raw = dec_ok(ADDU_CONTROL);
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                raw = dec_ok(5'd0);
      default:  raw = dec_ri();
    endcase

    // Without a multiply/divide unit the MD arithmetic ops are reserved.
    dec = raw;
    if (ENABLE_MD == 0 && (raw.mul || raw.div)) begin
      dec = dec_ri();
    end
  end

  assign control  = dec.ctrl;
  assign ri       = dec.ri;
  assign md_class = dec.md;
  assign is_mul   = dec.mul;
  assign is_div   = dec.div;

endmodule

`default_nettype wire

// File: rtl/alu_issue_dec.sv
// ============================================================================
// Module : alu_issue_dec
// Brief  : ID->EX ALU-control issue register with MULT/DIV busy tracking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_dec
  import alu_issue_dec_pkg::*;
#(
  parameter int CTRL_W     = 5,
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int ENABLE_MD  = 1,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [31:0]       inst,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              ri_excp,
  output logic              md_busy
);

  logic [4:0] dec_ctrl;
  logic       dec_ri;
  logic       dec_md;
  logic       dec_mul;
  logic       dec_div;
  logic       unused_inst;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ri_q, ri_d;
  logic              mul_q, mul_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hold;
  logic accept;
  logic take;

  alu_op_decode #(
    .ENABLE_MD (ENABLE_MD)
  ) u_dec (
    .op       (inst[31:26]),
    .funct    (inst[5:0]),
    .rs       (inst[25:21]),
    .rt       (inst[20:16]),
    .control  (dec_ctrl),
    .ri       (dec_ri),
    .md_class (dec_md),
    .is_mul   (dec_mul),
    .is_div   (dec_div)
  );

  assign unused_inst = ^inst[15:6];

  assign md_busy  = |cnt_q;
  assign hold     = md_busy && dec_md && !dec_ri;
  assign in_ready = (!valid_q || out_ready) && !hold;
  assign accept   = in_valid && in_ready;
  assign take     = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    ri_d    = ri_q;
    mul_d   = mul_q;
    div_d   = div_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = CTRL_W'(dec_ctrl);
      ri_d    = dec_ri;
      mul_d   = dec_mul;
      div_d   = dec_div;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  // The unit starts when EX takes the op; a later flush cannot recall it.
  always_comb begin
    cnt_d = cnt_q;
    if (take && !flush && (mul_q || div_q)) begin
      cnt_d = mul_q ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      ri_q    <= 1'b0;
      mul_q   <= 1'b0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      ri_q    <= ri_d;
      mul_q   <= mul_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign alucontrol = ctrl_q;
  assign ri_excp    = ri_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_dec.sv
// ============================================================================
// Module : tb_alu_issue_dec
// Brief  : Scoreboard bench for the ALU issue/decode stage.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue_dec;
  import alu_issue_dec_pkg::*;

  localparam int CTRL_W = 5;

  logic              clk       = 1'b0;
  logic              resetn    = 1'b1;
  logic              in_valid  = 1'b0;
  logic [31:0]       inst      = 32'h0;
  logic              flush     = 1'b0;
  logic              out_ready = 1'b1;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] alucontrol;
  logic              ri_excp;
  logic              md_busy;

  int checks      = 0;
  int errors      = 0;
  int busy_cycles = 0;
  logic [5:0] sb[$];

  typedef struct {
    logic [31:0] i;
    logic [4:0]  c;
    logic        r;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  alu_issue_dec dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .inst       (inst),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alucontrol (alucontrol),
    .ri_excp    (ri_excp),
    .md_busy    (md_busy)
  );

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h1234};
  endfunction

  // Scoreboard consumer: every register handoff to EX is compared in order.
  always @(negedge clk) begin
    logic [5:0] exp;
    if (resetn && md_busy) busy_cycles++;
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output ctrl=%0d ri=%b exp=none", alucontrol, ri_excp);
      end else begin
        exp = sb.pop_front();
        if (!flush) begin
          checks++;
          if ({alucontrol, ri_excp} !== exp) begin
            errors++;
            $display("FAIL sb_output ctrl=%0d ri=%b exp_ctrl=%0d exp_ri=%b",
                     alucontrol, ri_excp, exp[5:1], exp[0]);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [31:0] i, input logic [5:0] exp, input int max_wait,
                       input string name);
    int n = 0;
    inst     = i;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept in_ready=%b exp=1 waited=%0d", name, in_ready, n);
    end else begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (alucontrol !== '0) begin errors++; $display("FAIL reset_alucontrol got=%0d exp=0", alucontrol); end
    checks++; if (ri_excp !== 1'b0) begin errors++; $display("FAIL reset_ri_excp got=%b exp=0", ri_excp); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    repeat (2) sync();
    resetn = 1'b1;
    sync();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    issue(rtype(FN_ADDU), {ADDU_CONTROL, 1'b0}, 0, "addu");
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_out_valid got=%b exp=1", out_valid); end
    sync();
    issue(itype(6'h0d, 5'd2), {OR_CONTROL, 1'b0}, 0, "ori");
    sync();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_decode();
    vq.push_back('{rtype(6'h24), AND_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h27), NOR_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h00), SLL_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h07), SRAV_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h22), SUB_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h2b), SLTU_CONTROL, 1'b0});
    vq.push_back('{rtype(6'h09), ADDU_CONTROL, 1'b0});
    vq.push_back('{itype(6'h0f, 5'd2), LUI_CONTROL, 1'b0});
    vq.push_back('{itype(6'h08, 5'd2), ADD_CONTROL, 1'b0});
    vq.push_back('{itype(6'h0b, 5'd2), SLTU_CONTROL, 1'b0});
    vq.push_back('{itype(6'h0e, 5'd2), XOR_CONTROL, 1'b0});
    vq.push_back('{itype(6'h23, 5'd2), ADDU_CONTROL, 1'b0});
    vq.push_back('{itype(6'h2b, 5'd2), ADDU_CONTROL, 1'b0});
    vq.push_back('{{6'h03, 26'h0000100}, ADDU_CONTROL, 1'b0});
    vq.push_back('{itype(6'h01, 5'b10001), ADDU_CONTROL, 1'b0});
    vq.push_back('{{6'h10, 5'b00100, 5'd3, 5'd12, 11'h0}, MTC0_CONTROL, 1'b0});
    vq.push_back('{{6'h10, 5'b00000, 5'd3, 5'd12, 11'h0}, MFC0_CONTROL, 1'b0});
    vq.push_back('{32'h42000018, 5'd0, 1'b0});
    vq.push_back('{{6'h02, 26'h0000040}, 5'd0, 1'b0});
    vq.push_back('{itype(6'h04, 5'd2), 5'd0, 1'b0});
    vq.push_back('{itype(6'h01, 5'b00000), 5'd0, 1'b0});
    vq.push_back('{itype(6'h3f, 5'd2), 5'd0, 1'b1});
    vq.push_back('{rtype(6'h3f), 5'd0, 1'b1});
    vq.push_back('{itype(6'h01, 5'b00011), 5'd0, 1'b1});
    vq.push_back('{{6'h10, 5'b01111, 21'h0}, 5'd0, 1'b1});
    foreach (vq[k]) issue(vq[k].i, {vq[k].c, vq[k].r}, 0, "decode");
    repeat (2) sync();
  endtask

  task automatic test_div_hold();
    int n = 0;
    int held_bad = 0;
    busy_cycles = 0;
    issue(rtype(FN_DIV), {DIV_CONTROL, 1'b0}, 0, "div");
    repeat (4) sync();
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy got=%b exp=1", md_busy); end
    issue(rtype(FN_ADDU), {ADDU_CONTROL, 1'b0}, 0, "addu_in_busy");
    inst     = rtype(FN_MFLO);
    in_valid = 1'b1;
    @(negedge clk);
    while (md_busy === 1'b1 && n < 64) begin
      if (in_ready !== 1'b0) held_bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL mflo_hold leaked=%0d exp=0", held_bad); end
    checks++;
    if (busy_cycles != 32) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=32", busy_cycles); end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mflo_release in_ready=%b exp=1", in_ready);
    end else begin
      sb.push_back({MFLO_CONTROL, 1'b0});
    end
    sync();
    in_valid = 1'b0;
    repeat (2) sync();
  endtask

  task automatic test_stall();
    int bad = 0;
    out_ready = 1'b0;
    issue(rtype(FN_ADD), {ADD_CONTROL, 1'b0}, 0, "add_stall");
    inst     = rtype(6'h26);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alucontrol !== ADD_CONTROL) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold bad_cycles=%0d ctrl=%0d exp_ctrl=%0d", bad, alucontrol, ADD_CONTROL);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release in_ready=%b exp=1", in_ready);
    end else begin
      sb.push_back({XOR_CONTROL, 1'b0});
    end
    sync();
    in_valid = 1'b0;
    repeat (2) sync();
  endtask

  task automatic test_flush();
    int n = 0;
    busy_cycles = 0;
    out_ready   = 1'b1;
    issue(rtype(FN_DIV), {DIV_CONTROL, 1'b0}, 0, "div_flush");
    issue(rtype(FN_ADDU), {ADDU_CONTROL, 1'b0}, 0, "addu_flushed");
    flush    = 1'b1;
    inst     = itype(6'h0d, 5'd2);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    sync();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL flush_md_busy got=%b exp=1", md_busy); end
    while (md_busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_cycles != 32) begin errors++; $display("FAIL flush_busy_cycles got=%0d exp=32", busy_cycles); end
    sync();
  endtask

  task automatic test_async_reset();
    int n = 0;
    busy_cycles = 0;
    out_ready   = 1'b1;
    issue(rtype(FN_DIV), {DIV_CONTROL, 1'b0}, 0, "div_reset");
    sync();
    out_ready = 1'b0;
    issue(rtype(FN_ADDU), {ADDU_CONTROL, 1'b0}, 0, "addu_reset");
    while (busy_cycles < 16 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (md_busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL prereset_state md_busy=%b out_valid=%b exp=1/1", md_busy, out_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL async_md_busy got=%b exp=0", md_busy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (alucontrol !== '0) begin errors++; $display("FAIL async_alucontrol got=%0d exp=0", alucontrol); end
    sb.delete();
    sync();
    resetn    = 1'b1;
    out_ready = 1'b1;
    sync();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_div_hold();
    test_stall();
    test_flush();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_dec.md
Name: alu_issue_dec

Overview:
- Pipelined ALU-control decoder and issue stage between ID and EX of the MIPS core.
- Decodes the instruction word into an ALU control code.
- Registers the result behind a valid/ready handshake and flags reserved instructions.
- Tracks outstanding multi-cycle MULT/DIV operations so that dependent HI/LO instructions are held until the multiply/divide unit is free.

Parameters:
- CTRL_W, 5: width of alucontrol; codes are zero-extended from defines2.vh `*_CONTROL` values.
- MUL_CYCLES, 1: busy cycles after a MULT/MULTU issues (0 = single-cycle).
- DIV_CYCLES, 32: busy cycles after a DIV/DIVU issues.
- ENABLE_MD, 1: 0 = MULT/MULTU/DIV/DIVU decode as reserved instructions.
- CNT_W, 6: busy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  ID stage presents an instruction
- inst  in  32  instruction word; op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0]
- in_ready  out  1  stage accepts inst this cycle
- flush  in  1  kill the registered instruction (exception/branch redirect)
- out_valid  out  1  registered decode valid toward EX
- out_ready  in  1  EX accepts the registered decode
- alucontrol  out  CTRL_W  registered ALU control code
- ri_excp  out  1  registered reserved-instruction flag
- md_busy  out  1  multiply/divide unit busy (counter != 0)

Behaviour:
- Reset (resetn=0, asynchronous): out_valid=0, alucontrol=0, ri_excp=0, busy counter=0, md_busy=0.
- Decode is combinational from inst:
  - R-type funct: AND, NOR, OR, XOR, SLLV, SLL, SRAV, SRA, SRLV, SRL, MFHI, MTHI, MFLO, MTLO, ADD, ADDU, SUB, SUBU, SLT, SLTU, DIV, DIVU, MULT, MULTU map to their `*_CONTROL`. JALR maps to ADDU_CONTROL.
  - Immediates: ANDI→AND, ORI→OR, XORI→XOR, LUI→LUI, ADDI→ADD, ADDIU→ADDU, SLTI→SLT, SLTIU→SLTU.
  - JAL, BGEZAL, BLTZAL, and all loads/stores → ADDU_CONTROL.
  - SPECIAL3 with rs=MTC0/MFC0 → MTC0_CONTROL/MFC0_CONTROL.
  - J, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, ERET → control 0, ri=0.
  - Anything else, including an unknown R-type funct, an unknown REGIMM rt, or an unknown SPECIAL3 rs → control 0, ri=1.
- md_class: the decoded instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- hold = md_busy && md_class && !ri.
- in_ready = (!out_valid || out_ready) && !hold.
- Accept (in_valid && in_ready): the output register loads control/ri and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- If out_valid && out_ready && no accept: out_valid←0, and alucontrol/ri_excp keep their values.
- flush has priority over accept: out_valid←0 and the incoming instruction is dropped. in_ready is unaffected by flush.
- Busy counter:
  - Loads when EX takes the register (out_valid && out_ready && !flush) and the registered op is a MULT-class or DIV-class op. MULT/MULTU load MUL_CYCLES; DIV/DIVU load DIV_CYCLES.
  - Otherwise it decrements while nonzero and saturates at 0.
  - The load is cycle-exact: the counter holds N for one cycle, then N-1, and so on.
  - flush does NOT clear the counter; the unit completes regardless.
- Simultaneous load and decrement: load wins.
- Back-to-back DIV: the second DIV is held until the counter reaches 0, then accepted the same cycle md_busy falls.
- The registered output is stable while out_valid && !out_ready.
- ENABLE_MD=0: md ops set ri=1, never load the counter, and md_busy stays 0.

Decomposition:
- Opcode/funct/rs/rt and `*_CONTROL` constants stay in the shared defines2.vh. Add MD_MUL_CYCLES/MD_DIV_CYCLES defaults there.
- One natural combinational sub-module, alu_op_decode: (op, funct, rs, rt) → (control, ri, md_class, is_mul, is_div).
- The top holds the output register, the handshake and the busy counter.

Test Plan:
- Reset release, ADDU then ORI with out_ready=1 → out_valid one cycle after each accept, alucontrol = ADDU_CONTROL then OR_CONTROL, ri_excp=0.
- op=6'h3F or R-type funct 6'h3F → out_valid=1, alucontrol=0, ri_excp=1. ERET → ri_excp=0.
- DIV issued and taken at cycle T, then MFLO presented → md_busy=1 for exactly 32 cycles, in_ready=0 until md_busy falls, MFLO accepted that cycle. An ADDU presented during the busy window is accepted immediately.
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0, alucontrol held. Release → next instruction accepted the same cycle.
- flush with in_valid=1 → out_valid=0 next cycle. flush the cycle after DIV is taken → counter continues to 0.
- resetn asserted mid-DIV (counter=17) → md_busy and out_valid drop immediately, without waiting for a clock edge.
